sort_job_arbiter: RTL
=====================

SORT_JOB_ARBITER -- requirements
Module: sort_job_arbiter

Interface
REQ-001 SHALL have parameter SORT_LATENCY, default 1: cycles from sn_window update to stable sn_max/sn_med/sn_min; legal 1..15.
REQ-002 SHALL have port S_AXI_ACLK  input  1  clock; all logic on rising edge.
REQ-003 SHALL have port S_AXI_ARESETN  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports req0_valid / req1_valid  input  1  job request from requester 0 / 1.
REQ-005 SHALL have ports req0_ready / req1_ready  output  1  job accepted when valid and ready are both high.
REQ-006 SHALL have ports req0_window / req1_window  input  72  nine unsigned bytes {x1..x9}, with x1 in [71:64] and x9 in [7:0].
REQ-007 SHALL have port sn_window  output  72  registered inputs to the shared max/med/min sorting network, same byte order.
REQ-008 SHALL have ports sn_max, sn_med, sn_min  input  8 each  sorting network outputs.
REQ-009 SHALL have ports rsp0_valid / rsp1_valid  output  1  result available for requester 0 / 1.
REQ-010 SHALL have ports rsp0_ready / rsp1_ready  input  1  result consumed.
REQ-011 SHALL have ports rsp0_result / rsp1_result  output  24  {max[23:16], med[15:8], min[7:0]}.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, SORT and RESP; one job in flight at a time.
REQ-014 In IDLE, grant SHALL go to the single valid requester; if both are valid, grant SHALL go to the requester not served last (round-robin pointer `last`).
REQ-015 reqN_ready SHALL be combinational: high only in IDLE, only for the granted requester, and only when reqN_valid is high; the other ready SHALL stay low.
REQ-016 On the accept edge: sn_window <= window, owner <= N, cnt <= SORT_LATENCY, state <= SORT.
REQ-017 In SORT, cnt SHALL decrement each cycle; when cnt==1, the result register SHALL capture {sn_max,sn_med,sn_min} and state SHALL go to RESP.
REQ-018 Latency from accept edge to rspN_valid high SHALL be exactly SORT_LATENCY cycles.
REQ-019 In RESP, rsp<owner>_valid SHALL be high and hold the result stable until rsp<owner>_ready; the non-owner rsp valid SHALL be low.
REQ-020 On the response handshake: last <= owner, state <= IDLE; a new request SHALL be accepted no earlier than the following cycle.
REQ-021 Minimum job period SHALL be SORT_LATENCY+2 cycles.
REQ-022 sn_window SHALL hold its last value outside accept edges.
REQ-023 rspN_result SHALL show the result register for both ports at all times; consumers qualify it with valid.
REQ-024 Deasserting reqN_valid before accept SHALL be allowed; no request is latched without a handshake.

Reset
REQ-025 On S_AXI_ARESETN low: state=IDLE, last=1 (requester 0 wins the first tie), owner=0, cnt=0, sn_window=0, result=0, all valid/ready outputs=0, busy=0.
REQ-026 Reset asserted mid-SORT or mid-RESP SHALL drop the job silently; no response is issued after release.

Configuration
REQ-027 With macro SORT_JOB_ARBITER_STATS_EN defined, the block SHALL add outputs job_cnt0 and job_cnt1 (16 bits each), incremented on each response handshake of that requester, wrapping 0xFFFF->0x0000, and reset to 0.
REQ-028 Without SORT_JOB_ARBITER_STATS_EN, those ports and counters SHALL NOT exist; all other behaviour is identical.

Verification
REQ-029 Single job: SORT_LATENCY=1; req0 window 09_01_08_02_07_03_06_04_05 plus a behavioural sorter model -> rsp0_result=0x090501 exactly 1 cycle after accept; rsp1_valid stays 0.
REQ-030 Contention: both requesters valid continuously after reset, req0=all 0x11, req1=all 0x22 -> accept order 0,1,0,1; results 0x111111 and 0x222222 each go to the correct port.
REQ-031 Backpressure: SORT_LATENCY=3; rsp1_ready held low for 5 cycles -> rsp1_valid and result stable throughout; req0_ready stays 0 until 1 cycle after the rsp1 handshake.
REQ-032 Reset mid-SORT: SORT_LATENCY=4; assert reset 2 cycles after accept -> all outputs 0 immediately; no rsp valid after release; the next job completes normally.
REQ-033 Stats (STATS_EN defined): preload job_cnt0 to 0xFFFF via 65535 jobs, or by forcing the counter -> the next req0 response makes it 0x0000 while job_cnt1 is unchanged.

Source files
------------

// File: rtl/sort_job_arbiter_if.sv
// sort_job_arbiter_if: request, response and sorting-network signals of sort_job_arbiter.
interface sort_job_arbiter_if;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [71:0] req0_window, req1_window, sn_window;
    logic [7:0]  sn_max, sn_med, sn_min;
    logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [23:0] rsp0_result, rsp1_result;
    logic        busy;
    modport slave (
        input  req0_valid, req1_valid, req0_window, req1_window,
        input  sn_max, sn_med, sn_min, rsp0_ready, rsp1_ready,
        output req0_ready, req1_ready, sn_window, rsp0_valid, rsp1_valid,
        output rsp0_result, rsp1_result, busy
    );
    modport master (
        output req0_valid, req1_valid, req0_window, req1_window,
        output sn_max, sn_med, sn_min, rsp0_ready, rsp1_ready,
        input  req0_ready, req1_ready, sn_window, rsp0_valid, rsp1_valid,
        input  rsp0_result, rsp1_result, busy
    );
endinterface

// File: rtl/sort_job_arbiter.sv
// sort_job_arbiter: round-robin two-requester front end for a shared max/med/min sorting network.
// Optional per-requester job counters with SORT_JOB_ARBITER_STATS_EN.
module sort_job_arbiter #(
    parameter int unsigned SORT_LATENCY = 1
) (
    input logic S_AXI_ACLK,
    input logic S_AXI_ARESETN,
    sort_job_arbiter_if.slave bus
`ifdef SORT_JOB_ARBITER_STATS_EN
    ,
    output logic [15:0] job_cnt0,
    output logic [15:0] job_cnt1
`endif
);
    typedef enum logic [1:0] {IDLE, SORT, RESP} state_t;
    state_t state, state_nxt;
    logic last, owner, grant, accept, rsp_hs;
    logic [3:0] cnt;
    logic [23:0] result;
    always_comb begin
        // last==1 means requester 0 wins the next tie
        grant = (bus.req0_valid && bus.req1_valid) ? ~last : bus.req1_valid;
        bus.req0_ready = S_AXI_ARESETN && state == IDLE && bus.req0_valid && !grant;
        bus.req1_ready = S_AXI_ARESETN && state == IDLE && bus.req1_valid && grant;
        accept = bus.req0_ready || bus.req1_ready;
        bus.rsp0_valid = state == RESP && !owner;
        bus.rsp1_valid = state == RESP && owner;
        rsp_hs = (bus.rsp0_valid && bus.rsp0_ready) || (bus.rsp1_valid && bus.rsp1_ready);
        bus.busy = state != IDLE;
        bus.rsp0_result = result;
        bus.rsp1_result = result;
        state_nxt = (state == IDLE && accept) ? SORT :
                    (state == SORT && cnt == 4'd1) ? RESP :
                    (state == RESP && rsp_hs) ? IDLE : state;
    end
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state <= IDLE;
            last <= 1'b1;
            owner <= 1'b0;
            cnt <= 4'd0;
            bus.sn_window <= 72'd0;
            result <= 24'd0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                bus.sn_window <= bus.req1_ready ? bus.req1_window : bus.req0_window;
                owner <= bus.req1_ready;
                cnt <= 4'(SORT_LATENCY);
            end else if (state == SORT) begin
                cnt <= cnt - 4'd1;
            end
            if (state == SORT && cnt == 4'd1)
                result <= {bus.sn_max, bus.sn_med, bus.sn_min};
            if (rsp_hs)
                last <= owner;
        end
    end
`ifdef SORT_JOB_ARBITER_STATS_EN
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            job_cnt0 <= 16'd0;
            job_cnt1 <= 16'd0;
        end else begin
            if (bus.rsp0_valid && bus.rsp0_ready)
                job_cnt0 <= job_cnt0 + 16'd1;
            if (bus.rsp1_valid && bus.rsp1_ready)
                job_cnt1 <= job_cnt1 + 16'd1;
        end
    end
`endif
endmodule
